// File: rtl/cordic_angle_sequencer.sv
// Sequences one binary-angle request through an external CORDIC core.
// Folds quadrants 1/2 into the core's range and returns a sign-corrected, saturated result.
module cordic_angle_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_angle,
   output logic        core_start,
   output logic [15:0] core_angle,
   input  logic        core_done,
   input  logic [15:0] core_exp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic [1:0]  out_quadrant,
   output logic        out_timeout,
   output logic        busy
);

   localparam int DATA_W = 16;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      HOLD
   } state_t;

   state_t                     state;
   state_t                     state_next;
   logic        [CNT_W-1:0]    cnt;
   logic                       negate;
   logic signed [DATA_W-1:0]   result;
   logic                       limit_hit;

   // Two's-complement negation with the single overflow case clamped to max positive.
   function automatic logic signed [DATA_W-1:0] sat_negate(input logic signed [DATA_W-1:0] x);
      if (x == {1'b1, {(DATA_W-1){1'b0}}})
         return {1'b0, {(DATA_W-1){1'b1}}};
      return -x;
   endfunction

   assign limit_hit  = (cnt == CNT_LIMIT);
   assign out_result = result;

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      core_start = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid)
               state_next = LAUNCH;
         end
         LAUNCH: begin
            core_start = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (core_done || limit_hit)
               state_next = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, wait counter and result registers; core_done only matters in WAIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         core_angle   <= '0;
         negate       <= 1'b0;
         out_quadrant <= 2'b00;
         cnt          <= '0;
         result       <= '0;
         out_timeout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  negate       <= in_angle[15] ^ in_angle[14];
                  core_angle   <= (in_angle[15] ^ in_angle[14]) ? (in_angle ^ 16'h8000) : in_angle;
                  out_quadrant <= in_angle[15:14];
               end
            end
            LAUNCH: cnt <= '0;
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (core_done) begin
                  result      <= negate ? sat_negate(signed'(core_exp)) : signed'(core_exp);
                  out_timeout <= 1'b0;
               end else if (limit_hit) begin
                  result      <= '0;
                  out_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Scoreboard bench for cordic_angle_sequencer: directed transactions with hand-computed results.
// Stimulus queues expectations; a negedge monitor checks core_angle at core_start and results at handshake.
module tb_cordic_angle_sequencer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_angle;
   logic        core_start;
   logic [15:0] core_angle;
   logic        core_done;
   logic [15:0] core_exp;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [1:0]  out_quadrant;
   logic        out_timeout;
   logic        busy;

   typedef struct packed {
      logic [15:0] result;
      logic [1:0]  quadrant;
      logic        timeout;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] angle_q[$];
   int          tests = 0;
   int          fails = 0;
   int          start_count = 0;

   cordic_angle_sequencer #(.TIMEOUT_CYCLES(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_angle     (in_angle),
      .core_start   (core_start),
      .core_angle   (core_angle),
      .core_done    (core_done),
      .core_exp     (core_exp),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_quadrant (out_quadrant),
      .out_timeout  (out_timeout),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: decoupled from stimulus, compares against queued expectations.
   always @(negedge clk) begin
      if (core_start) begin
         start_count++;
         if (angle_q.size() == 0) begin
            check("unexpected_core_start", 32'd1, 32'd0);
         end else begin
            logic [15:0] a;
            a = angle_q.pop_front();
            check("core_angle", 32'(core_angle), 32'(a));
         end
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_result", 32'(out_result), 32'(e.result));
            check("out_quadrant", 32'(out_quadrant), 32'(e.quadrant));
            check("out_timeout", 32'(out_timeout), 32'(e.timeout));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and drive the core model until HOLD is reached (no handshake).
   // dly < 0 means the core never answers.
   task automatic launch_txn(input logic [15:0] angle, input logic [15:0] cexp, input int dly,
                             input logic [15:0] req_core_angle, input exp_t e);
      int cyc;
      cyc = 0;
      while (!in_ready && cyc < 200) begin
         tick();
         cyc++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      angle_q.push_back(req_core_angle);
      exp_q.push_back(e);
      in_valid = 1'b1;
      in_angle = angle;
      tick();
      in_valid = 1'b0;
      if (dly >= 0) begin
         tick();
         repeat (dly) tick();
         core_done = 1'b1;
         core_exp  = cexp;
         tick();
         core_done = 1'b0;
         check("out_valid_latency", 32'(out_valid), 32'd1);
      end else begin
         cyc = 0;
         while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
         end
         check("timeout_latency", 32'(cyc), 32'd65);
      end
   endtask

   task automatic finish_txn();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("ready_after_hold", 32'(in_ready), 32'd1);
      check("busy_after_hold", 32'(busy), 32'd0);
      check("valid_after_hold", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int s0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_angle  = 16'h0;
      core_done = 1'b0;
      core_exp  = 16'h0;
      out_ready = 1'b0;
      repeat (3) tick();

      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_core_start", 32'(core_start), 32'd0);
      check("rst_core_angle", 32'(core_angle), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_out_quadrant", 32'(out_quadrant), 32'd0);
      check("rst_out_timeout", 32'(out_timeout), 32'd0);
      reset = 1'b1;
      tick();

      // Stray core_done while idle must be ignored.
      core_done = 1'b1;
      core_exp  = 16'h4321;
      tick();
      core_done = 1'b0;
      check("idle_done_busy", 32'(busy), 32'd0);
      check("idle_done_valid", 32'(out_valid), 32'd0);

      // Scenario 1: quadrant 0, pass-through.
      launch_txn(16'h2000, 16'h1234, 4, 16'h2000, '{16'h1234, 2'd0, 1'b0});
      finish_txn();
      // Scenario 2: quadrant 2, folded and negated.
      launch_txn(16'hA000, 16'h1234, 2, 16'h2000, '{16'hEDCC, 2'd2, 1'b0});
      finish_txn();
      // Scenario 3: quadrant 1, negation saturates.
      launch_txn(16'h7000, 16'h8000, 0, 16'hF000, '{16'h7FFF, 2'd1, 1'b0});
      finish_txn();
      // Scenario 4: core silent, timeout after 64 WAIT cycles.
      launch_txn(16'h4000, 16'h0000, -1, 16'hC000, '{16'h0000, 2'd1, 1'b1});
      finish_txn();
      // core_done on the final WAIT cycle wins over the timeout.
      launch_txn(16'hE000, 16'h7FFF, 63, 16'hE000, '{16'h7FFF, 2'd3, 1'b0});
      finish_txn();

      // Scenario 5: downstream stall with a pending upstream request.
      launch_txn(16'hC000, 16'h0100, 1, 16'hC000, '{16'h0100, 2'd3, 1'b0});
      s0 = start_count;
      in_valid = 1'b1;
      in_angle = 16'h1111;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall_result", 32'(out_result), 32'h0100);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
      end
      check("stall_no_restart", 32'(start_count - s0), 32'd0);
      in_valid = 1'b0;
      finish_txn();

      // Scenario 6: reset during WAIT cycle 3, followed by a late core_done.
      angle_q.push_back(16'h1000);
      in_valid = 1'b1;
      in_angle = 16'h9000;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset     = 1'b1;
      core_done = 1'b1;
      core_exp  = 16'h5555;
      tick();
      core_done = 1'b0;
      check("mid_rst_core_angle", 32'(core_angle), 32'd0);
      check("mid_rst_out_result", 32'(out_result), 32'd0);
      check("mid_rst_out_quadrant", 32'(out_quadrant), 32'd0);
      check("mid_rst_out_timeout", 32'(out_timeout), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("mid_rst_out_valid", 32'(out_valid), 32'd0);
         tick();
      end

      check("result_queue_empty", 32'(exp_q.size()), 32'd0);
      check("angle_queue_empty", 32'(angle_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
